video_timing_rx: RTL and testbench

Sink-side counterpart of the HDMI video timing generator. It accepts a parallel RGB565 stream with active-low HS/VS and active-high DE, all in the pixel clock domain, and recovers per-pixel x/y coordinates plus frame and line markers. It also measures the incoming line and frame geometry and declares lock after consecutive identical frames. It sits between an HDMI/DVI receiver front end (or a loopback of the generator) and downstream ISP/frame-buffer writers.

---
 rtl/video_timing_pkg.sv | 25 ++
 rtl/video_timing_rx_edge_det.sv | 28 ++
 rtl/video_timing_rx.sv | 197 +++++++++++++++++++
 tb/tb_video_timing_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types for the video timing receiver: default widths, lock FSM states
// and the measured-geometry record.
package video_timing_pkg;

  localparam int CNT_W_DEF = 13;
  localparam int POS_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } vt_state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] h_total;
    logic [CNT_W_DEF-1:0] h_active;
    logic [CNT_W_DEF-1:0] v_total;
    logic [CNT_W_DEF-1:0] v_active;
  } geo_t;

  function automatic logic geo_differs(input geo_t a, input geo_t b);
    return (a != b);
  endfunction

endpackage

// File: rtl/video_timing_rx_edge_det.sv
// One-bit input register with rise/fall pulses taken between the registered
// sample and the sample before it.
module video_edge_det (
  input  logic pixel_clk,
  input  logic sys_rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;

  // two-deep sample history; reset to 0 so a low input at release is not seen as a fall
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign rise = s1_r & ~s2_r;
  assign fall = ~s1_r & s2_r;

endmodule

// File: rtl/video_timing_rx.sv
// Video timing receiver: recovers pixel coordinates from HS/VS/DE, measures
// line/frame geometry and declares lock after consecutive identical frames.
module video_timing_rx
  import video_timing_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int LOCK_FRAMES = 2,
  parameter int HS_TIMEOUT  = 4400
) (
  input  logic             pixel_clk,
  input  logic             sys_rst,
  input  logic             video_hs,
  input  logic             video_vs,
  input  logic             video_de,
  input  logic [15:0]      video_rgb,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic [POS_W-1:0] pix_x,
  output logic [POS_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [CNT_W-1:0] meas_h_total,
  output logic [CNT_W-1:0] meas_h_active,
  output logic [CNT_W-1:0] meas_v_total,
  output logic [CNT_W-1:0] meas_v_active,
  output logic             locked,
  output logic             timing_err
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] POS_MAX   = '1;
  localparam logic [POS_W-1:0] POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HS_TO     = CNT_W'(HS_TIMEOUT);
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_FRAMES - 1);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] v);
    return (v == POS_MAX) ? v : v + POS_ONE;
  endfunction

  logic hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s, de_rise_s, de_fall_s;
  logic de_lvl_s;
  logic de_on_r;
  logic [15:0] rgb_s1_r;
  logic [CNT_W-1:0] h_cnt_r, h_len_r, col_cnt_r, h_act_r, v_line_r, de_lines_r;
  logic armed_r, first_line_r;
  vt_state_e state_r, state_nxt_s;
  logic [3:0] match_cnt_r, match_nxt_s, match_inc_s;
  geo_t geo_r, geo_nxt_s, cur_geo_s;
  logic err_nxt_s;

  video_edge_det u_hs_det (.pixel_clk(pixel_clk), .sys_rst(sys_rst), .d(video_hs),
                           .rise(hs_rise_s), .fall(hs_fall_s));
  video_edge_det u_vs_det (.pixel_clk(pixel_clk), .sys_rst(sys_rst), .d(video_vs),
                           .rise(vs_rise_s), .fall(vs_fall_s));
  video_edge_det u_de_det (.pixel_clk(pixel_clk), .sys_rst(sys_rst), .d(video_de),
                           .rise(de_rise_s), .fall(de_fall_s));

  // de_on_r mirrors the previous DE sample, so this rebuilds the registered DE level
  assign de_lvl_s = de_rise_s | (de_on_r & ~de_fall_s);

  // snapshot of the frame just ending; a coincident HS fall or DE fall closes the last line now
  always_comb begin
    cur_geo_s.h_total  = hs_fall_s ? h_cnt_r : h_len_r;
    cur_geo_s.h_active = de_fall_s ? col_cnt_r : h_act_r;
    cur_geo_s.v_total  = v_line_r;
    cur_geo_s.v_active = de_lines_r;
  end

  // lock FSM next state: geometry compare at each armed VS fall, HS watchdog while locked
  always_comb begin
    state_nxt_s = state_r;
    match_nxt_s = match_cnt_r;
    geo_nxt_s   = geo_r;
    err_nxt_s   = 1'b0;
    match_inc_s = match_cnt_r + 4'd1;
    if (vs_fall_s && armed_r) begin
      case (state_r)
        ST_UNLOCK: begin
          geo_nxt_s   = cur_geo_s;
          match_nxt_s = 4'd0;
          state_nxt_s = ST_TRACK;
        end
        ST_TRACK: begin
          if (geo_differs(cur_geo_s, geo_r)) begin
            geo_nxt_s   = cur_geo_s;
            match_nxt_s = 4'd0;
          end else if (match_inc_s >= LOCK_LAST) begin
            match_nxt_s = match_inc_s;
            state_nxt_s = ST_LOCKED;
          end else begin
            match_nxt_s = match_inc_s;
          end
        end
        ST_LOCKED: begin
          if (geo_differs(cur_geo_s, geo_r)) begin
            err_nxt_s   = 1'b1;
            geo_nxt_s   = cur_geo_s;
            match_nxt_s = 4'd0;
            state_nxt_s = ST_TRACK;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default: state_nxt_s = ST_UNLOCK;
      endcase
    end else if ((state_r == ST_LOCKED) && (h_cnt_r >= HS_TO)) begin
      err_nxt_s   = 1'b1;
      match_nxt_s = 4'd0;
      state_nxt_s = ST_UNLOCK;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // counters, measurement latches, pixel output stage and FSM state register
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      de_on_r       <= 1'b0;
      rgb_s1_r      <= '0;
      h_cnt_r       <= '0;
      h_len_r       <= '0;
      col_cnt_r     <= '0;
      h_act_r       <= '0;
      v_line_r      <= '0;
      de_lines_r    <= '0;
      armed_r       <= 1'b0;
      first_line_r  <= 1'b1;
      state_r       <= ST_UNLOCK;
      match_cnt_r   <= 4'd0;
      geo_r         <= '0;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      meas_h_total  <= '0;
      meas_h_active <= '0;
      meas_v_total  <= '0;
      meas_v_active <= '0;
      locked        <= 1'b0;
      timing_err    <= 1'b0;
    end else begin
      de_on_r  <= de_lvl_s;
      rgb_s1_r <= video_rgb;

      h_cnt_r <= hs_fall_s ? CNT_ONE : cnt_inc(h_cnt_r);
      if (hs_fall_s) h_len_r <= h_cnt_r;

      if (de_lvl_s) col_cnt_r <= de_rise_s ? CNT_ONE : cnt_inc(col_cnt_r);
      if (de_fall_s) h_act_r <= col_cnt_r;

      // an HS fall or DE rise on the VS fall belongs to the new frame
      if (vs_fall_s) begin
        v_line_r   <= hs_fall_s ? CNT_ONE : '0;
        de_lines_r <= de_rise_s ? CNT_ONE : '0;
        armed_r    <= 1'b1;
      end else begin
        if (hs_fall_s) v_line_r <= cnt_inc(v_line_r);
        if (de_rise_s) de_lines_r <= cnt_inc(de_lines_r);
      end

      if (vs_fall_s && armed_r) begin
        meas_h_total  <= cur_geo_s.h_total;
        meas_h_active <= cur_geo_s.h_active;
        meas_v_total  <= cur_geo_s.v_total;
        meas_v_active <= cur_geo_s.v_active;
      end

      frame_start <= vs_fall_s;
      pix_valid   <= de_lvl_s & locked;
      pix_data    <= rgb_s1_r;
      line_start  <= de_rise_s;
      if (de_lvl_s) pix_x <= de_rise_s ? '0 : pos_inc(pix_x);

      if (de_rise_s) begin
        pix_y        <= (first_line_r || vs_fall_s) ? '0 : pos_inc(pix_y);
        first_line_r <= 1'b0;
      end else if (vs_fall_s) begin
        first_line_r <= 1'b1;
      end

      state_r     <= state_nxt_s;
      match_cnt_r <= match_nxt_s;
      geo_r       <= geo_nxt_s;
      locked      <= (state_nxt_s == ST_LOCKED);
      timing_err  <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// Randomized-pixel bench for video_timing_rx with a frame-level reference model
// and a pixel scoreboard drained by an independent monitor.
module tb_video_timing_rx;

  localparam int LOCK_FRAMES = 2;
  localparam int HS_TIMEOUT  = 4400;

  logic        pixel_clk = 1'b0;
  logic        sys_rst;
  logic        video_hs, video_vs, video_de;
  logic [15:0] video_rgb;
  logic        pix_valid, line_start, frame_start, locked, timing_err;
  logic [15:0] pix_data;
  logic [11:0] pix_x, pix_y;
  logic [12:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;

  video_timing_rx #(.CNT_W(13), .POS_W(12), .LOCK_FRAMES(LOCK_FRAMES), .HS_TIMEOUT(HS_TIMEOUT)) dut (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de), .video_rgb(video_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start),
    .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
    .meas_v_total(meas_v_total), .meas_v_active(meas_v_active),
    .locked(locked), .timing_err(timing_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct { int x; int y; logic [15:0] d; } pix_t;
  typedef struct packed { int ht; int ha; int vt; int va; } geo_m_t;

  pix_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     err_seen = 0;
  int     exp_err  = 0;
  int     pv_cnt   = 0;

  // reference model: frame-level lock rule expressed as a run length of identical frames
  bit     m_armed  = 1'b0;
  bit     m_locked = 1'b0;
  int     run_len  = 0;
  geo_m_t g_prev   = '0;
  geo_m_t g_last   = '0;
  geo_m_t exp_meas = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_vs(output bit pulse);
    pulse = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      if (run_len == 0) run_len = 1;
      else if (g_last == g_prev) run_len++;
      else begin
        if (m_locked) pulse = 1'b1;
        run_len = 1;
      end
      g_prev   = g_last;
      exp_meas = g_last;
      m_locked = (run_len >= LOCK_FRAMES);
    end
    if (pulse) exp_err++;
  endtask

  task automatic model_reset();
    m_armed  = 1'b0;
    m_locked = 1'b0;
    run_len  = 0;
    exp_meas = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
    chk({tag, "_pulses"}, {line_start, frame_start, timing_err}, 0);
    chk({tag, "_meas"}, meas_h_total | meas_h_active | meas_v_total | meas_v_active, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  task automatic drive_frame(input int H, input int A, input int V, input int VA,
                             input int HSW, input int VSW, input int HST, input int VST,
                             input int gl_line, input int gl_col, input int rst_line);
    bit pulse = 1'b0;
    bit prev_de = 1'b0;
    bit rst_c;
    int yi = -1;
    int xi = 0;
    for (int ln = 0; ln < V; ln++) begin
      for (int h = 0; h < H; h++) begin
        if (ln == 0 && h == 0) model_vs(pulse);
        rst_c     = (ln == rst_line) && (h >= 1) && (h <= 3);
        sys_rst   = rst_c;
        video_hs  = !(h < HSW);
        video_vs  = !(ln < VSW);
        video_de  = ((ln >= VST) && (ln < VST + VA) && (h >= HST) && (h < HST + A)) ||
                    ((ln == gl_line) && (h == gl_col));
        video_rgb = 16'($urandom);
        if (rst_c && h == 1) model_reset();
        if (video_de) begin
          if (!prev_de) begin yi++; xi = 0; end
          if (m_locked) exp_q.push_back('{x: xi, y: yi, d: video_rgb});
          xi++;
        end
        prev_de = video_de;
        @(posedge pixel_clk); #1;
        if (ln == 0 && h == 1) begin
          chk("timing_err_pulse", timing_err, pulse);
          chk("frame_start_pulse", frame_start, 1);
        end
        if (ln == 0 && h == 2) begin
          chk("pulses_one_cycle", {timing_err, frame_start}, 0);
          chk("meas_h_total", meas_h_total, exp_meas.ht);
          chk("meas_h_active", meas_h_active, exp_meas.ha);
          chk("meas_v_total", meas_v_total, exp_meas.vt);
          chk("meas_v_active", meas_v_active, exp_meas.va);
          chk("locked", locked, m_locked);
        end
        if (rst_c && h == 3) check_all_zero("midframe_reset");
      end
    end
    sys_rst = 1'b0;
    g_last = '{ht: H, ha: A, vt: V, va: VA + ((gl_line >= 0) ? 1 : 0)};
  endtask

  task automatic frame_m();
    drive_frame(60, 40, 16, 12, 4, 3, 10, 3, -1, 0, -1);
  endtask

  task automatic frame_s(input int H, input int gl_line, input int rst_line);
    drive_frame(H, 8, 10, 4, 2, 2, 6, 3, gl_line, int'($urandom_range(19, 2)), rst_line);
  endtask

  // scoreboard monitor: every presented pixel must match the oldest expected one
  always @(negedge pixel_clk) begin
    if (sys_rst === 1'b0) begin
      if (timing_err === 1'b1) err_seen++;
      if (pix_valid === 1'b1) begin
        pv_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          chk("pix_x", pix_x, e.x);
          chk("pix_y", pix_y, e.y);
          chk("pix_data", pix_data, e.d);
          chk("line_start", line_start, (e.x == 0) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    sys_rst = 1'b1; video_hs = 1'b1; video_vs = 1'b1; video_de = 1'b0; video_rgb = 16'h0000;
    repeat (4) @(posedge pixel_clk);
    #1;
    check_all_zero("reset");
    sys_rst = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;

    repeat (4) frame_m();
    repeat (3) frame_s(20, -1, -1);
    frame_s(20, 1, -1);
    repeat (3) frame_s(20, -1, -1);
    repeat (3) frame_s(24, -1, -1);
    frame_s(24, -1, 4);
    repeat (4) frame_s(24, -1, -1);

    // HS stalls while locked: watchdog must drop lock and stop pixels
    video_hs = 1'b1; video_vs = 1'b1; video_de = 1'b0;
    chk("locked_before_stall", locked, 1);
    exp_err++;
    for (int i = 0; i < 5200; i++) begin
      @(posedge pixel_clk); #1;
      if (i == 3999) chk("locked_within_timeout", locked, 1);
    end
    chk("locked_after_timeout", locked, 0);
    pv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      video_de = 1'b1; video_rgb = 16'($urandom);
      @(posedge pixel_clk); #1;
    end
    video_de = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("pix_valid_after_timeout", pv_cnt, 0);
    chk("timing_err_count", err_seen, exp_err);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
